// File: rtl/cg_store_pkg.sv
// ---------------------------------------------------------------------------
// cg_store_pkg
// Shared definitions for the solver vector store: the read-sequencer state
// encoding and helpers that size the banked row memory from the system
// geometry (clusters x equations spread over no_of_units elements per row).
// ---------------------------------------------------------------------------
package cg_store_pkg;

    // Read sequencer states: waiting, issuing row addresses, and one extra
    // cycle to let the final registered RAM read reach the output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } readState_t;

    // Number of rows needed to hold n elements packed units-per-row.
    function automatic int calcDepth(input int n, input int units);
        return (n + units - 1) / units;
    endfunction

    // Row-index width for a memory of the given depth (at least one bit).
    function automatic int calcAddrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cg_vector_ram.sv
// ---------------------------------------------------------------------------
// cg_vector_ram
// Simple dual-port row memory: one write port, one registered read port.
// A read and a write to the same row on the same edge return the row's
// previous contents (read-before-write). Array contents are never cleared;
// only the read-data register is reset.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (read-data register only)
//   i_wrEn     write i_wrData into row i_wrAddr
//   i_wrAddr   write row index
//   i_wrData   write row data
//   i_rdEn     capture row i_rdAddr into o_rdData on this edge
//   i_rdAddr   read row index
//   o_rdData   registered read data (one cycle after i_rdEn)
// ---------------------------------------------------------------------------
module cg_vector_ram
    import cg_store_pkg::*;
#(
    parameter int DEPTH = 95,
    parameter int WIDTH = 512,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wrEn,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read port; non-blocking semantics give the old row when
    // the same row is written on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rdData <= '0;
        end else if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/cg_vector_store.sv
// ---------------------------------------------------------------------------
// cg_vector_store
// Collects one solver vector from the ALU result port row by row and streams
// the completed vector back out, one row per cycle, for the next iteration.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   wr_en         write wr_data into row write_counter
//   wr_data       ALU result row (no_of_units elements)
//   rd_start      pulse: stream the whole held vector out
//   rd_hold       stall the read stream for this cycle
//   rd_data       streamed row
//   rd_valid      rd_data valid this cycle
//   rd_last       asserted with the final row
//   rd_address    row index of rd_data
//   write_counter next row to be written
//   vector_done   one-cycle pulse after the final row is written
//   vector_valid  a complete vector is held
//   busy          read sequencer not idle
// ---------------------------------------------------------------------------
module cg_vector_store
    import cg_store_pkg::*;
#(
    parameter int number_of_clusters              = 40,
    parameter int number_of_equations_per_cluster = 19,
    parameter int element_width                   = 64,
    parameter int no_of_units                     = 8,
    parameter int memory_read_address_width       = 20
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [no_of_units*element_width-1:0]   wr_data,
    input  logic                                   rd_start,
    input  logic                                   rd_hold,
    output logic [no_of_units*element_width-1:0]   rd_data,
    output logic                                   rd_valid,
    output logic                                   rd_last,
    output logic [memory_read_address_width-1:0]   rd_address,
    output logic [31:0]                            write_counter,
    output logic                                   vector_done,
    output logic                                   vector_valid,
    output logic                                   busy
);

    localparam int N     = number_of_clusters * number_of_equations_per_cluster;
    localparam int DEPTH = calcDepth(N, no_of_units);
    localparam int WIDTH = no_of_units * element_width;
    localparam int AW    = calcAddrWidth(DEPTH);
    localparam logic [31:0]   LAST_ROW   = 32'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

    readState_t r_state;
    readState_t w_nextState;

    logic [31:0]                          r_writeCounter;
    logic [AW-1:0]                        r_rdPtr;
    logic                                 r_vectorValid;
    logic                                 r_clearPending;
    logic                                 r_vectorDone;
    logic                                 r_rdValid;
    logic                                 r_rdLast;
    logic [memory_read_address_width-1:0] r_rdAddress;

    logic          w_wrap;
    logic          w_row0Hit;
    logic          w_start;
    logic          w_issue;
    logic          w_issueLast;
    logic [AW-1:0] w_wrAddr;

    assign w_wrAddr    = r_writeCounter[AW-1:0];
    assign w_wrap      = wr_en && (r_writeCounter == LAST_ROW);
    assign w_row0Hit   = wr_en && (r_writeCounter == 32'd0) && r_vectorValid;
    assign w_start     = (r_state == IDLE) && rd_start && r_vectorValid;
    assign w_issue     = (r_state == READ) && !rd_hold;
    assign w_issueLast = w_issue && (r_rdPtr == LAST_PTR);

    // Row memory; the read port is driven by the sequencer's row pointer.
    cg_vector_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .i_wrEn   (wr_en),
        .i_wrAddr (w_wrAddr),
        .i_wrData (wr_data),
        .i_rdEn   (w_issue),
        .i_rdAddr (r_rdPtr),
        .o_rdData (rd_data)
    );

    // Read sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Read sequencer next state: a start is only honoured from IDLE with a
    // complete vector held; DRAIN covers the RAM's one-cycle read latency.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = READ;
            READ:    if (w_issueLast) w_nextState = DRAIN;
            DRAIN:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Row pointer: restarts on an accepted start and advances on every
    // non-held READ cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
        end else if (w_start) begin
            r_rdPtr <= '0;
        end else if (w_issue) begin
            r_rdPtr <= r_rdPtr + AW'(1);
        end
    end

    // Write counter: advances on each write and wraps after the final row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_writeCounter <= '0;
            r_vectorDone   <= 1'b0;
        end else begin
            r_vectorDone <= w_wrap;
            if (wr_en) begin
                r_writeCounter <= w_wrap ? 32'd0 : r_writeCounter + 32'd1;
            end
        end
    end

    // Vector-valid flag. Completing a vector always sets it. Starting a new
    // vector (row 0 write) clears it, except while a read is streaming the
    // old vector: then the clear waits for the DRAIN cycle so the stream
    // finishes against a valid vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vectorValid  <= 1'b0;
            r_clearPending <= 1'b0;
        end else if (w_wrap) begin
            r_vectorValid  <= 1'b1;
            r_clearPending <= 1'b0;
        end else if ((r_state == DRAIN) && (r_clearPending || w_row0Hit)) begin
            r_vectorValid  <= 1'b0;
            r_clearPending <= 1'b0;
        end else if (w_row0Hit) begin
            if (r_state == IDLE) begin
                r_vectorValid <= 1'b0;
            end else begin
                r_clearPending <= 1'b1;
            end
        end
    end

    // Output qualifiers aligned with the registered RAM read data. The
    // address holds its last value across held or idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdValid   <= 1'b0;
            r_rdLast    <= 1'b0;
            r_rdAddress <= '0;
        end else begin
            r_rdValid <= w_issue;
            r_rdLast  <= w_issueLast;
            if (w_issue) begin
                r_rdAddress <= memory_read_address_width'(r_rdPtr);
            end
        end
    end

    assign rd_valid      = r_rdValid;
    assign rd_last       = r_rdLast;
    assign rd_address    = r_rdAddress;
    assign write_counter = r_writeCounter;
    assign vector_done   = r_vectorDone;
    assign vector_valid  = r_vectorValid;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_cg_vector_store.sv
// ---------------------------------------------------------------------------
// tb_cg_vector_store
// Self-checking bench for cg_vector_store: directed scenarios followed by a
// randomized phase, checked every cycle against a transaction-level model of
// the vector store, plus literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_cg_vector_store;

    localparam int UNITS = 8;
    localparam int EW    = 64;
    localparam int WIDTH = UNITS * EW;
    localparam int DEPTH = (40 * 19 + UNITS - 1) / UNITS;
    localparam int RAW   = 20;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_start;
    logic             rd_hold;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic [RAW-1:0]   rd_address;
    logic [31:0]      write_counter;
    logic             vector_done;
    logic             vector_valid;
    logic             busy;

    int vectors;
    int miscompares;

    cg_vector_store dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .rd_start      (rd_start),
        .rd_hold       (rd_hold),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .rd_address    (rd_address),
        .write_counter (write_counter),
        .vector_done   (vector_done),
        .vector_valid  (vector_valid),
        .busy          (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] mMem [DEPTH];
    bit               mKnown [DEPTH];
    int               mWc;
    bit               mVV;
    bit               mPend;
    bit               mReading;
    bit               mDrain;
    int               mRow;

    bit               expValid;
    bit               expLast;
    bit               expBusy;
    bit               expDone;
    bit               expKnown;
    int               expAddr;
    logic [WIDTH-1:0] expData;

    // Observation statistics gathered from the DUT for literal checks.
    int               cycleNo;
    int               beats;
    int               lastCount;
    int               lastAddr;
    int               firstCycle;
    int               lastCycle;
    int               doneCount;
    logic [WIDTH-1:0] obsData [DEPTH];

    function automatic logic [WIDTH-1:0] rep(input logic [EW-1:0] e);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < UNITS; i++) r[i*EW +: EW] = e;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] randRow();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic resetModel();
        mWc = 0; mVV = 0; mPend = 0; mReading = 0; mDrain = 0; mRow = 0;
        expValid = 0; expLast = 0; expBusy = 0; expDone = 0;
        expKnown = 0; expAddr = 0; expData = '0;
    endtask

    // One clock edge of the vector store, described as a stream of whole
    // transactions: a running read walks rows in order, writes fill rows in
    // order, and the vector-valid flag follows fill/restart events.
    task automatic modelStep();
        bit oldReading = mReading;
        bit oldDrain   = mDrain;
        bit oldVV      = mVV;
        bit busyOld    = oldReading || oldDrain;
        bit row0Hit    = wr_en && (mWc == 0) && oldVV;

        expDone  = wr_en && (mWc == DEPTH - 1);
        expValid = 0;
        expLast  = 0;

        if (oldDrain) begin
            mDrain = 0;
            if (mPend) begin mVV = 0; mPend = 0; end
        end
        if (oldReading && !rd_hold) begin
            expValid = 1;
            expAddr  = mRow;
            expKnown = mKnown[mRow];
            expData  = mMem[mRow];
            expLast  = (mRow == DEPTH - 1);
            if (expLast) begin mReading = 0; mDrain = 1; end
            else mRow++;
        end
        if (!busyOld && rd_start && oldVV) begin
            mReading = 1;
            mRow     = 0;
        end
        if (wr_en) begin
            if (row0Hit) begin
                if (!busyOld || oldDrain) begin mVV = 0; mPend = 0; end
                else mPend = 1;
            end
            mMem[mWc]   = wr_data;
            mKnown[mWc] = 1;
            if (mWc == DEPTH - 1) begin
                mWc = 0; mVV = 1; mPend = 0;
            end else begin
                mWc++;
            end
        end
        expBusy = mReading || mDrain;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearStats();
        beats = 0; lastCount = 0; lastAddr = -1;
        firstCycle = -1; lastCycle = -1; doneCount = 0;
        for (int i = 0; i < DEPTH; i++) obsData[i] = '0;
    endtask

    // Drive one cycle of inputs; returns just after the edge that samples them.
    task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] d,
                                 input logic st, input logic hd);
        wr_en = we; wr_data = d; rd_start = st; rd_hold = hd;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_start = 1'b0; rd_hold = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Model advances on every active edge while out of reset.
    always @(posedge clk) begin
        if (reset) modelStep();
    end

    // Compare process: every cycle out of reset, DUT against model.
    always @(negedge clk) begin
        int idx;
        cycleNo++;
        if (reset) begin
            checkOutput("rd_valid", WIDTH'(rd_valid), WIDTH'(expValid));
            checkOutput("rd_last", WIDTH'(rd_last), WIDTH'(expLast));
            checkOutput("busy", WIDTH'(busy), WIDTH'(expBusy));
            checkOutput("rd_address", WIDTH'(rd_address), WIDTH'(expAddr));
            checkOutput("write_counter", WIDTH'(write_counter), WIDTH'(mWc));
            checkOutput("vector_done", WIDTH'(vector_done), WIDTH'(expDone));
            checkOutput("vector_valid", WIDTH'(vector_valid), WIDTH'(mVV));
            if (expValid && expKnown) checkOutput("rd_data", rd_data, expData);
            if (rd_valid) begin
                beats++;
                if (firstCycle < 0) firstCycle = cycleNo;
                lastCycle = cycleNo;
                idx = int'(rd_address);
                if (idx < DEPTH) obsData[idx] = rd_data;
                if (rd_last) begin lastCount++; lastAddr = idx; end
            end
            if (vector_done) doneCount++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; cycleNo = 0;
        wr_en = 0; wr_data = '0; rd_start = 0; rd_hold = 0;
        for (int i = 0; i < DEPTH; i++) begin mMem[i] = '0; mKnown[i] = 0; end
        clearStats();
        resetModel();

        // Reset state.
        reset = 1'b0;
        #1;
        checkOutput("reset_rd_valid", WIDTH'(rd_valid), '0);
        checkOutput("reset_busy", WIDTH'(busy), '0);
        checkOutput("reset_wc", WIDTH'(write_counter), '0);
        checkOutput("reset_vv", WIDTH'(vector_valid), '0);
        checkOutput("reset_rd_data", rd_data, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Fill one vector with row r = r replicated.
        $display("[TB] fill");
        clearStats();
        for (int r = 0; r < DEPTH; r++) applyStimulus(1'b1, rep(64'(r)), 1'b0, 1'b0);
        checkOutput("fill_done_now", WIDTH'(vector_done), WIDTH'(1));
        checkOutput("fill_wc", WIDTH'(write_counter), '0);
        checkOutput("fill_vv", WIDTH'(vector_valid), WIDTH'(1));
        idle(1);
        checkOutput("fill_done_after", WIDTH'(vector_done), '0);
        checkOutput("fill_done_count", WIDTH'(doneCount), WIDTH'(1));

        // Plain stream.
        $display("[TB] stream");
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stream_busy_t1", WIDTH'(busy), WIDTH'(1));
        checkOutput("stream_valid_t1", WIDTH'(rd_valid), '0);
        idle(100);
        checkOutput("stream_beats", WIDTH'(beats), WIDTH'(95));
        checkOutput("stream_last_count", WIDTH'(lastCount), WIDTH'(1));
        checkOutput("stream_last_addr", WIDTH'(lastAddr), WIDTH'(94));
        checkOutput("stream_span", WIDTH'(lastCycle - firstCycle + 1), WIDTH'(95));
        checkOutput("stream_row0", obsData[0], rep(64'd0));
        checkOutput("stream_row47", obsData[47], rep(64'd47));
        checkOutput("stream_row94", obsData[94], rep(64'd94));

        // Hold for three cycles while row 10 is addressed.
        $display("[TB] hold");
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        idle(100);
        checkOutput("hold_beats", WIDTH'(beats), WIDTH'(95));
        checkOutput("hold_span", WIDTH'(lastCycle - firstCycle + 1), WIDTH'(98));
        checkOutput("hold_row10", obsData[10], rep(64'd10));
        checkOutput("hold_row11", obsData[11], rep(64'd11));

        // Overwrite row 5 in the cycle it is read, then re-complete and reread.
        $display("[TB] read-before-write");
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int r = 0; r < DEPTH; r++)
            applyStimulus(1'b1, (r == 5) ? rep(64'hAAAA_AAAA_AAAA_AAAA) : rep(64'(r)), 1'b0, 1'b0);
        idle(5);
        checkOutput("rbw_first_row5", obsData[5], rep(64'd5));
        checkOutput("rbw_first_beats", WIDTH'(beats), WIDTH'(95));
        checkOutput("rbw_vv", WIDTH'(vector_valid), WIDTH'(1));
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(100);
        checkOutput("rbw_second_row5", obsData[5], rep(64'hAAAA_AAAA_AAAA_AAAA));
        checkOutput("rbw_second_row6", obsData[6], rep(64'd6));

        // Reset at row 40 of a stream.
        $display("[TB] reset mid-stream");
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(41);
        checkOutput("abort_addr40", WIDTH'(rd_address), WIDTH'(40));
        checkOutput("abort_valid_before", WIDTH'(rd_valid), WIDTH'(1));
        reset = 1'b0;
        #1;
        resetModel();
        checkOutput("abort_rd_valid", WIDTH'(rd_valid), '0);
        checkOutput("abort_rd_last", WIDTH'(rd_last), '0);
        checkOutput("abort_busy", WIDTH'(busy), '0);
        checkOutput("abort_rd_address", WIDTH'(rd_address), '0);
        checkOutput("abort_vv", WIDTH'(vector_valid), '0);
        checkOutput("abort_wc", WIDTH'(write_counter), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(5);
        checkOutput("ignored_busy", WIDTH'(busy), '0);
        checkOutput("ignored_beats", WIDTH'(beats), '0);
        checkOutput("ignored_addr", WIDTH'(rd_address), '0);
        for (int r = 0; r < DEPTH; r++) applyStimulus(1'b1, rep(64'(r + 1000)), 1'b0, 1'b0);
        checkOutput("refill_vv", WIDTH'(vector_valid), WIDTH'(1));
        clearStats();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(100);
        checkOutput("refill_beats", WIDTH'(beats), WIDTH'(95));
        checkOutput("refill_row40", obsData[40], rep(64'd1040));

        // Randomized traffic against the model.
        $display("[TB] random");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, randRow(),
                          ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
        end
        idle(110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cg_vector_store.md
# cg_vector_store

Banked result-vector buffer that receives the solver ALU's per-cycle vector outputs (P, R, X, PP, RR result words with their write enables) and streams the completed vector back out, one row per cycle, to feed the next iteration's operand inputs. It is the write-side collector and read-side sequencer for one solver vector. One instance is used per vector (P, R, X, ...). It sits between the complex ALU result ports and the operand ports of the ALU top level.

## Interface
Parameters:
- `number_of_clusters`, 40, clusters in the system
- `number_of_equations_per_cluster`, 19, equations per cluster
- `element_width`, 64, bits per complex element
- `no_of_units`, 8, elements per row (one ALU output beat)
- `memory_read_address_width`, 20, width of `rd_address`
- derived: `N` = clusters × equations = 760; `DEPTH` = ceil(`N`/`no_of_units`) = 95 rows

Ports:
- `clk`, in, 1, sole clock, rising edge
- `reset`, in, 1, asynchronous, active-low
- `wr_en`, in, 1, write one row
- `wr_data`, in, `no_of_units`×`element_width`, ALU result row
- `rd_start`, in, 1, pulse: stream whole vector out
- `rd_hold`, in, 1, stall the read stream
- `rd_data`, out, `no_of_units`×`element_width`, streamed row
- `rd_valid`, out, 1, `rd_data` valid this cycle
- `rd_last`, out, 1, with final row (`DEPTH`-1)
- `rd_address`, out, `memory_read_address_width`, row index of `rd_data`
- `write_counter`, out, 32, next row to be written
- `vector_done`, out, 1, one-cycle pulse when row `DEPTH`-1 is written
- `vector_valid`, out, 1, a complete vector is held
- `busy`, out, 1, read FSM not idle

## Operation
- Reset (asserted low, asynchronous): all outputs 0, FSM to IDLE, `write_counter`=0, `vector_valid`=0. RAM contents are not cleared.
- Write side:
  - `wr_en`=1 writes `wr_data` to row `write_counter`, then increments the counter.
  - At row `DEPTH`-1 the counter wraps to 0, `vector_done` pulses in the next cycle, and `vector_valid` is set.
  - `wr_en` at row 0 while `vector_valid`=1 clears `vector_valid`, unless a read is in progress. In that case the clear is deferred to the read's end.
- Read FSM:
  - IDLE → READ on `rd_start`=1 with `vector_valid`=1. `rd_start` in any other condition is ignored; no queuing.
  - READ: issues rows 0..`DEPTH`-1, one per non-held cycle. `rd_hold`=1 freezes the row pointer and deasserts `rd_valid` on the corresponding output cycle.
  - After the row `DEPTH`-1 address is issued → DRAIN, for one cycle of RAM latency, then → IDLE.
- RAM is read-before-write. A write and a read to the same row in the same cycle returns the old data.
- Writes are accepted in every FSM state.

## Timing
- RAM read latency: 1 cycle.
- `rd_start` sampled at edge t:
  - `busy`=1 from t+1.
  - Row 0 appears at t+2 with `rd_valid`=1 and `rd_address`=0.
  - Without holds, row k appears at t+2+k.
  - `rd_last`=1 together with row `DEPTH`-1 at t+1+`DEPTH`.
  - `busy`=0 from t+2+`DEPTH`.
- `rd_hold`=1 at edge h: no `rd_valid` at h+1, and the next row is delayed by one cycle. `rd_hold` has no effect outside READ.
- `vector_done`: high exactly one cycle, the cycle after the wrapping write.
- Reset mid-read: stream aborts immediately; `rd_valid`, `rd_last` and `busy` go to 0 asynchronously.

## Structure
- Shared package `cg_store_pkg`:
  - `DEPTH` computation function
  - FSM state enum: IDLE, READ, DRAIN
- Sub-module `cg_vector_ram`: simple dual-port, one write port and one read port, registered read, read-before-write, depth `DEPTH`, width `no_of_units`×`element_width`.
- The top level holds the write counter, flags, FSM and output registers.

## Test plan
- Write 95 rows, row r data = r replicated per element → `vector_done` high exactly once, in the cycle after the 95th write; `write_counter` returns to 0; `vector_valid`=1.
- `rd_start` after the fill → 95 consecutive `rd_valid` beats with data 0..94 and matching `rd_address`; `rd_last` only on 94; `busy` falls 1 cycle after `rd_last`.
- `rd_start` with `vector_valid`=0 → `busy`, `rd_valid` and `rd_address` stay 0.
- `rd_hold` high for 3 cycles during row 10 → gap of 3 cycles in `rd_valid`, rows remain contiguous 10, 11, ..., total 95 beats.
- Write row 5 with 0xAA..A in the cycle row 5 is addressed → stream shows old value 5; a second read shows 0xAA..A.
- Assert `reset` at row 40 of a stream → all outputs 0 the same cycle; `vector_valid`=0; a subsequent `rd_start` is ignored until 95 new writes.
